// File: rtl/somador_serial_ctrl.sv
// somador_serial_ctrl
// Bit-serial adder controller. A single 1-bit full adder is evaluated once
// per cycle. Starting at the LSB it adds the operand shift registers and the
// carry flop. After WIDTH add cycles the assembled sum and the final carry
// are transferred to the output registers, and done pulses for one cycle.
//
// Parameters
//   WIDTH  operand/sum width in bits (2..32), default 8
//
// Ports
//   clk    in   1      single clock, rising edge
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request one addition (accepted in IDLE or DONE)
//   a      in   WIDTH  operand A, sampled only on acceptance
//   b      in   WIDTH  operand B, sampled only on acceptance
//   cin    in   1      carry-in, sampled only on acceptance
//   busy   out  1      high while add cycles are in progress
//   done   out  1      one-cycle pulse: s/cout hold a fresh result
//   s      out  WIDTH  registered sum
//   cout   out  1      registered carry-out
//   ovf    out  1      two's-complement overflow, registered with s
//                      (present only when SOMADOR_SERIAL_OVF_EN is defined)
//
// Configuration macro: SOMADOR_SERIAL_OVF_EN

module somador_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef SOMADOR_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  // The counter must be able to represent WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_sum;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_add;
  logic [1:0]       fa;
  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] sum_shifted;

  // One-bit full adder: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y,
                                          input logic c);
    logic p;
    p = x ^ y;
    return {(x & y) | (c & p), p ^ c};
  endfunction

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_add = (state == RUN) && (cnt == LAST_CNT);

  assign fa          = full_add(sh_a[0], sh_b[0], carry);
  assign sum_bit     = fa[0];
  assign carry_nxt   = fa[1];
  // New sum bits enter at the MSB side. After WIDTH shifts the first
  // (least significant) bit has reached bit 0.
  assign sum_shifted = {sum_bit, sh_sum[WIDTH-1:1]};

  // ---- FSM: state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- FSM: next-state logic ----
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      // The transfer happens on the edge of the final add, so the result
      // is visible in the same cycle that done is high.
      RUN:  if (cnt == LAST_CNT) state_nxt = DONE;
      DONE: state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // ---- Datapath: operand/sum shift registers, carry flop, counter ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a   <= '0;
      sh_b   <= '0;
      sh_sum <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      sh_a   <= a;
      sh_b   <= b;
      sh_sum <= '0;
      carry  <= cin;
      cnt    <= '0;
    end else if (state == RUN) begin
      sh_a   <= sh_a >> 1;
      sh_b   <= sh_b >> 1;
      sh_sum <= sum_shifted;
      carry  <= carry_nxt;
      cnt    <= cnt + CW'(1);
    end
  end

  // ---- Result registers: updated only on the final add cycle ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s    <= '0;
      cout <= 1'b0;
    end else if (last_add) begin
      s    <= sum_shifted;
      cout <= carry_nxt;
    end
  end

`ifdef SOMADOR_SERIAL_OVF_EN
  // On the final add the carry flop holds the carry into the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (last_add) begin
      ovf <= carry ^ carry_nxt;
    end
  end
`endif

endmodule
